// File: rtl/program_loader_if.sv
// Byte-stream input, memory write port and load status of the boot loader.
// The source side (stream producer / memory observer) uses the master modport;
// the loader itself uses the slave modport.
interface program_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              cpu_run;
  logic              load_busy;
  logic              load_error;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_addr, mem_wdata, mem_we,
    input  cpu_run, load_busy, load_error, words_loaded
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_addr, mem_wdata, mem_we,
    output cpu_run, load_busy, load_error, words_loaded
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: count byte, little-endian 32-bit words to memory from address 0, XOR checksum, then CPU release.
// Latency: 4th byte of a word accepted at edge k -> mem_we in the cycle after k; checksum at edge k -> cpu_run/load_error from k.
// Backpressure: in_ready low during the write cycle and after RUN/ERROR; an unaccepted byte must be held by the source.
module program_loader #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  program_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_WRITE, S_CHECK, S_RUN, S_ERROR
  } state_t;

  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CAP = 1 << ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] last_q, last_d;     // address of the final word (N-1)
  logic [ADDR_W-1:0] addr_q, addr_d;     // address of the word being assembled
  logic [1:0]        idx_q, idx_d;       // byte lane of the next data byte
  logic [23:0]       word_q, word_d;     // lower three lanes; the 4th byte goes straight out
  logic [7:0]        xor_q, xor_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic [TW-1:0]     to_q, to_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       mdata_q, mdata_d;
  logic              mwe_q, mwe_d;
  logic              accept;

  // in_ready is decoded from state but forced low while reset is held
  assign bus.in_ready = ~rst & ((state_q == S_IDLE) | (state_q == S_RECV) | (state_q == S_CHECK));
  assign accept       = bus.in_valid & bus.in_ready;

  assign bus.mem_addr     = maddr_q;
  assign bus.mem_wdata    = mdata_q;
  assign bus.mem_we       = mwe_q;
  assign bus.cpu_run      = (state_q == S_RUN);
  assign bus.load_error   = (state_q == S_ERROR);
  assign bus.load_busy    = (state_q == S_RECV) | (state_q == S_WRITE) | (state_q == S_CHECK);
  assign bus.words_loaded = wl_q;

  // Next-state, datapath and memory-port update
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    word_d  = word_q;
    xor_d   = xor_q;
    wl_d    = wl_q;
    to_d    = to_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    mwe_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          xor_d  = bus.in_data;
          idx_d  = 2'd0;
          addr_d = '0;
          wl_d   = '0;
          to_d   = '0;
          // A count of zero means a full memory image
          last_d = (bus.in_data == 8'd0) ? {ADDR_W{1'b1}} : ADDR_W'(bus.in_data - 8'd1);
          // Counts beyond capacity are only possible for narrow address spaces
          state_d = (int'(bus.in_data) > CAP) ? S_ERROR : S_RECV;
        end
      end
      S_RECV: begin
        if (accept) begin
          xor_d = xor_q ^ bus.in_data;
          to_d  = '0;
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0: word_d[7:0]   = bus.in_data;
            2'd1: word_d[15:8]  = bus.in_data;
            2'd2: word_d[23:16] = bus.in_data;
            default: begin
              mwe_d   = 1'b1;
              maddr_d = addr_q;
              mdata_d = {bus.in_data, word_q};
              state_d = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        wl_d = wl_q + 1'b1;
        if (addr_q == last_q) begin
          state_d = S_CHECK;
        end else begin
          addr_d  = addr_q + 1'b1;
          to_d    = '0;
          state_d = S_RECV;
        end
      end
      S_CHECK: begin
        if (accept) begin
          to_d    = '0;
          state_d = (bus.in_data == xor_q) ? S_RUN : S_ERROR;
        end
      end
      S_RUN:   state_d = S_RUN;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    // Stall watchdog: only mid-frame waiting states count
    if ((TIMEOUT > 0) && !accept && ((state_q == S_RECV) || (state_q == S_CHECK))) begin
      if (to_q == TW'(TIMEOUT - 1)) begin
        state_d = S_ERROR;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      xor_q   <= '0;
      wl_q    <= '0;
      to_q    <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
      mwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      xor_q   <= xor_d;
      wl_q    <= wl_d;
      to_q    <= to_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      mwe_q   <= mwe_d;
    end
  end

endmodule
